// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package   : mem_pkg
// Purpose   : Shared types and constants for the memory data-port arbiter:
//             FSM states, requester identifiers, access sizes and the
//             address range check used when a request is granted.
// Revision  : 1.0  initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} arb_state_t;
  typedef enum logic       {PORT_CPU, PORT_EXT} port_t;
  typedef enum logic       {SZ_BYTE, SZ_HALF} size_t;

  localparam int unsigned DEF_RAMSIZE   = 4096;
  localparam int unsigned DEF_NUM_BANKS = 3;
  localparam int unsigned MEM_LIMIT     = DEF_NUM_BANKS * DEF_RAMSIZE;
  localparam int unsigned BYTE_W        = 8;

  // True when any byte touched by the access lies outside 0 .. limit-1.
  // at_top flags the all-ones address, whose +1 would wrap in the port width.
  function automatic logic out_of_range(input logic [31:0] addr,
                                        input size_t       sz,
                                        input logic [31:0] limit,
                                        input logic        at_top);
    if (sz == SZ_HALF) begin
      return at_top || ((addr + 32'd1) >= limit);
    end
    return addr >= limit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Purpose   : One requester's request/response channel into the arbiter.
//   req   requester -> arbiter  request; fields held stable until ack
//   we    requester -> arbiter  1 = write, 0 = read
//   size  requester -> arbiter  0 = byte, 1 = halfword (little-endian)
//   addr  requester -> arbiter  byte address
//   wdata requester -> arbiter  write data (byte access uses [7:0])
//   ack   arbiter -> requester  one-cycle completion pulse
//   rdata arbiter -> requester  read data, valid with ack
//   err   arbiter -> requester  address out of range, valid with ack
// Revision  : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req;
  logic             we;
  logic             size;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  logic             err;

  modport master (output req, we, size, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, size, addr, wdata, output ack, rdata, err);
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module    : rr_arbiter2
// Purpose   : Two-way round-robin arbiter. On a tie the port that was not
//             granted last wins. last_grant updates only when en_i is high
//             and a grant is actually made.
//   clk, rst   clock, asynchronous active-high reset
//   req_i[0]   cpu request, req_i[1] ext request
//   en_i       arbitration enable (grant is being taken this cycle)
//   gnt_vld_o  some port is requesting
//   gnt_o      port chosen this cycle
// Revision  : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_vld_o,
  output port_t      gnt_o
);

  port_t last_q, last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_o     = PORT_CPU;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == PORT_CPU) ? PORT_EXT : PORT_CPU;
    end else if (req_i[1]) begin
      gnt_o = PORT_EXT;
    end
    last_d = last_q;
    if (en_i && gnt_vld_o) begin
      last_d = gnt_o;
    end
  end

  // Resetting to ext lets the cpu win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_EXT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : mem_port_arbiter
// Purpose   : Shares the 8-bit memory data port between the pipeline MEM
//             stage (cpu) and the loader (ext). Round-robin arbitration,
//             halfword accesses split into two byte beats, range check
//             against the RAM banks, and a stall for the pipeline.
//   clk, rst     clock, asynchronous active-high reset
//   cpu, ext     requester channels (mem_port_arbiter_if.slave)
//   cpu_stall_o  cpu.req & ~cpu.ack
//   mem_we_o     memory write enable
//   mem_a_o      memory byte address
//   mem_wd_o     memory write data {8'h00, byte}
//   mem_rd_i     memory read byte, valid the cycle after mem_a_o
// Revision  : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAMSIZE   = 4096,
  parameter int unsigned NUM_BANKS = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   cpu,
  mem_port_arbiter_if.slave   ext,
  output logic                cpu_stall_o,
  output logic                mem_we_o,
  output logic [WIDTH-1:0]    mem_a_o,
  output logic [WIDTH-1:0]    mem_wd_o,
  input  logic [BYTE_W-1:0]   mem_rd_i
);

  localparam logic [31:0] LIMIT = 32'(NUM_BANKS * RAMSIZE);

  arb_state_t        state_q, state_d;
  port_t             port_q,  port_d;
  logic              we_q,    we_d;
  size_t             size_q,  size_d;
  logic [WIDTH-1:0]  addr_q,  addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              err_q,   err_d;
  logic [BYTE_W-1:0] rbuf_q,  rbuf_d;

  logic              gnt_vld;
  port_t             gnt;
  logic              sel_we;
  size_t             sel_size;
  logic [WIDTH-1:0]  sel_addr;
  logic [WIDTH-1:0]  sel_wdata;
  logic              done;
  logic [WIDTH-1:0]  rdata;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({ext.req, cpu.req}),
    .en_i      (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  always_comb begin
    sel_we    = (gnt == PORT_EXT) ? ext.we    : cpu.we;
    sel_size  = size_t'((gnt == PORT_EXT) ? ext.size : cpu.size);
    sel_addr  = (gnt == PORT_EXT) ? ext.addr  : cpu.addr;
    sel_wdata = (gnt == PORT_EXT) ? ext.wdata : cpu.wdata;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          port_d  = gnt;
          we_d    = sel_we;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = out_of_range(32'(sel_addr), sel_size, LIMIT, &sel_addr);
          // Out-of-range requests complete without any memory cycle.
          state_d = err_d ? DONE : LO;
        end
      end
      LO:      state_d = (size_q == SZ_HALF) ? HI : DONE;
      HI: begin
        rbuf_d  = mem_rd_i;  // low byte, addressed in LO
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Outputs decode from registered state only; in DONE the last byte is
  // taken straight from mem_rd_i, which belongs to the preceding beat.
  always_comb begin
    mem_we_o = 1'b0;
    mem_a_o  = '0;
    mem_wd_o = '0;
    case (state_q)
      LO: begin
        mem_we_o = we_q;
        mem_a_o  = addr_q;
        mem_wd_o = WIDTH'(wdata_q[BYTE_W-1:0]);
      end
      HI: begin
        mem_we_o = we_q;
        mem_a_o  = addr_q + WIDTH'(1);
        mem_wd_o = WIDTH'(wdata_q[2*BYTE_W-1:BYTE_W]);
      end
      default: ;
    endcase

    done  = (state_q == DONE);
    rdata = '0;
    if (!err_q && !we_q) begin
      rdata = (size_q == SZ_HALF) ? WIDTH'({mem_rd_i, rbuf_q}) : WIDTH'(mem_rd_i);
    end

    cpu.ack     = done && (port_q == PORT_CPU);
    cpu.err     = cpu.ack && err_q;
    cpu.rdata   = cpu.ack ? rdata : '0;
    ext.ack     = done && (port_q == PORT_EXT);
    ext.err     = ext.ack && err_q;
    ext.rdata   = ext.ack ? rdata : '0;
    cpu_stall_o = cpu.req && !cpu.ack;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_mem_port_arbiter
// Purpose   : Directed self-checking bench for mem_port_arbiter with a
//             byte-wide synchronous-read memory model on the data port.
// Revision  : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_stall;
  logic        mem_we;
  logic [15:0] mem_a;
  logic [15:0] mem_wd;
  logic [7:0]  mem_rd;

  mem_port_arbiter_if #(.WIDTH(16)) cpu_if ();
  mem_port_arbiter_if #(.WIDTH(16)) ext_if ();

  mem_port_arbiter #(.WIDTH(16), .RAMSIZE(4096), .NUM_BANKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu_if.slave),
    .ext         (ext_if.slave),
    .cpu_stall_o (cpu_stall),
    .mem_we_o    (mem_we),
    .mem_a_o     (mem_a),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: write on edge, registered read.
  logic [7:0]  mem [0:16383];
  logic [15:0] wlog_a[$];
  logic [15:0] wlog_d[$];
  int          n_writes = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[13:0]] <= mem_wd[7:0];
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_wd);
      n_writes <= n_writes + 1;
    end
    mem_rd <= mem[mem_a[13:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Single transaction on one port; called just after a rising edge.
  task automatic xfer(input bit sel, input logic we, input logic sz,
                      input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic er, output int lat);
    if (!sel) begin
      cpu_if.we = we; cpu_if.size = sz; cpu_if.addr = a; cpu_if.wdata = wd; cpu_if.req = 1'b1;
    end else begin
      ext_if.we = we; ext_if.size = sz; ext_if.addr = a; ext_if.wdata = wd; ext_if.req = 1'b1;
    end
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!sel ? cpu_if.ack : ext_if.ack) begin
        lat = k;
        rd  = !sel ? cpu_if.rdata : ext_if.rdata;
        er  = !sel ? cpu_if.err   : ext_if.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!sel) cpu_if.req = 1'b0; else ext_if.req = 1'b0;
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat;
  int          n0;
  int          order[$];
  int          cdone, edone;
  logic        got_c, got_e;
  logic [7:0]  cvals[3];
  logic [7:0]  evals[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.size = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ext_if.req = 0; ext_if.we = 0; ext_if.size = 0; ext_if.addr = '0; ext_if.wdata = '0;
    cvals = '{8'h11, 8'h22, 8'h33};
    evals = '{8'h44, 8'h55, 8'h66};

    // 1: reset held with both requests high, then cpu wins first tie
    cpu_if.req = 1'b1; cpu_if.addr = 16'h0010;
    ext_if.req = 1'b1; ext_if.addr = 16'h0011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_ack", cpu_if.ack, 0);
    check_eq("rst_ext_ack", ext_if.ack, 0);
    check_eq("rst_mem_we",  mem_we, 0);
    check_eq("rst_mem_a",   mem_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = -1; got_c = 0; got_e = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cpu_if.ack || ext_if.ack) begin
        lat = k; got_c = cpu_if.ack; got_e = ext_if.ack;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("first_gnt_cpu", got_c, 1);
    check_eq("first_gnt_ext", got_e, 0);
    check_eq("first_lat", lat, 2);
    @(posedge clk); #1;
    cpu_if.req = 0; ext_if.req = 0;

    // 2: byte write then byte read
    xfer(0, 1, 0, 16'h0010, 16'h00AB, rd, er, lat);
    check_eq("bw_lat", lat, 2);
    check_eq("bw_rdata", rd, 0);
    check_eq("bw_err", er, 0);
    xfer(0, 0, 0, 16'h0010, 16'h0000, rd, er, lat);
    check_eq("br_lat", lat, 2);
    check_eq("br_rdata", rd, 16'h00AB);

    // 3: halfword across bank boundary
    n0 = wlog_a.size();
    xfer(0, 1, 1, 16'h0FFF, 16'hBEEF, rd, er, lat);
    check_eq("hw_lat", lat, 3);
    check_eq("hw_nbeats", wlog_a.size() - n0, 2);
    if (wlog_a.size() >= n0 + 2) begin
      check_eq("hw_a0",  wlog_a[n0],     16'h0FFF);
      check_eq("hw_wd0", wlog_d[n0],     16'h00EF);
      check_eq("hw_a1",  wlog_a[n0 + 1], 16'h1000);
      check_eq("hw_wd1", wlog_d[n0 + 1], 16'h00BE);
    end
    xfer(0, 0, 1, 16'h0FFF, 16'h0000, rd, er, lat);
    check_eq("hr_lat", lat, 3);
    check_eq("hr_rdata", rd, 16'hBEEF);

    // preload read data for the contention test through the loader port
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1, 0, 16'h0020 + 16'(i), {8'h00, cvals[i]}, rd, er, lat);
      xfer(1, 1, 0, 16'h0030 + 16'(i), {8'h00, evals[i]}, rd, er, lat);
    end

    // reset pulse so the first tie goes to cpu again
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 4: three back-to-back byte reads on each port
    cdone = 0; edone = 0;
    cpu_if.we = 0; cpu_if.size = 0; cpu_if.addr = 16'h0020; cpu_if.req = 1'b1;
    ext_if.we = 0; ext_if.size = 0; ext_if.addr = 16'h0030; ext_if.req = 1'b1;
    for (int cyc = 0; cyc < 60 && (cdone < 3 || edone < 3); cyc++) begin
      @(negedge clk);
      got_c = cpu_if.ack; got_e = ext_if.ack;
      if (cpu_if.req && !got_c) check_eq("rr_stall", cpu_stall, 1);
      if (got_c) begin
        check_eq("rr_cpu_rdata", cpu_if.rdata, {8'h00, cvals[cdone]});
        cdone++; order.push_back(0);
      end
      if (got_e) begin
        check_eq("rr_ext_rdata", ext_if.rdata, {8'h00, evals[edone]});
        edone++; order.push_back(1);
      end
      @(posedge clk); #1;
      if (got_c) begin
        if (cdone < 3) cpu_if.addr = 16'h0020 + 16'(cdone); else cpu_if.req = 1'b0;
      end
      if (got_e) begin
        if (edone < 3) ext_if.addr = 16'h0030 + 16'(edone); else ext_if.req = 1'b0;
      end
    end
    check_eq("rr_count", order.size(), 6);
    if (order.size() == 6) begin
      for (int i = 0; i < 6; i++) check_eq("rr_order", order[i], i % 2);
    end
    cpu_if.req = 0; ext_if.req = 0;

    // 5: out-of-range accesses on ext never touch memory
    n0 = n_writes;
    xfer(1, 1, 0, 16'h3000, 16'h0055, rd, er, lat);
    check_eq("oor_w_lat", lat, 1);
    check_eq("oor_w_err", er, 1);
    xfer(1, 0, 1, 16'h2FFF, 16'h0000, rd, er, lat);
    check_eq("oor_h_lat", lat, 1);
    check_eq("oor_h_err", er, 1);
    check_eq("oor_h_rdata", rd, 0);
    check_eq("oor_no_we", n_writes - n0, 0);
    xfer(0, 1, 0, 16'h2FFF, 16'h005A, rd, er, lat);
    check_eq("top_byte_err", er, 0);
    check_eq("top_byte_lat", lat, 2);

    // 6: reset during the high beat of a halfword write
    xfer(1, 1, 0, 16'h0100, 16'h0000, rd, er, lat);
    xfer(1, 1, 0, 16'h0101, 16'h0077, rd, er, lat);
    cpu_if.we = 1; cpu_if.size = 1; cpu_if.addr = 16'h0100; cpu_if.wdata = 16'h1234; cpu_if.req = 1'b1;
    @(posedge clk); #1;   // LO
    @(posedge clk); #1;   // HI
    @(negedge clk);
    check_eq("abort_hi_a", mem_a, 16'h0101);
    rst = 1'b1;
    #1;
    check_eq("abort_we", mem_we, 0);
    check_eq("abort_ack", cpu_if.ack, 0);
    cpu_if.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 0, 0, 16'h0100, 16'h0000, rd, er, lat);
    check_eq("abort_lo_kept", rd, 16'h0034);
    xfer(0, 0, 0, 16'h0101, 16'h0000, rd, er, lat);
    check_eq("abort_hi_untouched", rd, 16'h0077);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
